// File: rtl/pwm_duty_ramp_pkg.sv
// Shared definitions for the PWM duty path: duty width and limits, the
// nominal PWM period, and the ramp state encoding.
package pwm_duty_ramp_pkg;

    localparam int DUTY_W            = 8;
    localparam int PWM_DUTY_MAX      = 250;
    localparam int PWM_PERIOD_CYCLES = 2500;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_STOPPED   = 2'd3
    } ramp_state_e;

    // Saturate a requested duty code to the full-on code.
    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] duty,
        input logic [DUTY_W-1:0] duty_max
    );
        logic [DUTY_W-1:0] res;
        if (duty > duty_max) begin
            res = duty_max;
        end else begin
            res = duty;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter with a divider that emits one update
// strobe every TICK_PERIODS periods. Runs independently of any consumer.
module pwm_period_tick #(
    parameter int PERIOD_CYCLES = 2500,
    parameter int TICK_PERIODS  = 1
) (
    input  logic clock,
    input  logic reset,
    output logic update_tick
);

    localparam int PCW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TCW = (TICK_PERIODS > 1) ? $clog2(TICK_PERIODS) : 1;
    localparam logic [PCW-1:0] PCNT_LAST = PCW'(PERIOD_CYCLES - 1);
    localparam logic [TCW-1:0] TCNT_LAST = TCW'(TICK_PERIODS - 1);

    logic [PCW-1:0] r_period_cnt;
    logic [TCW-1:0] r_tick_cnt;
    logic           w_period_tick;
    logic           w_tick_last;

    assign w_period_tick = (r_period_cnt == PCNT_LAST);
    assign w_tick_last   = (r_tick_cnt == TCNT_LAST);
    assign update_tick   = w_period_tick & w_tick_last;

    // Period counter: wraps at the last cycle of each PWM period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_period_cnt <= '0;
        end else if (w_period_tick) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + PCW'(1);
        end
    end

    // Tick divider: counts completed periods, wraps on the update period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_period_tick) begin
            if (w_tick_last) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + TCW'(1);
            end
        end else begin
            r_tick_cnt <= r_tick_cnt;
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter in front of the PWM generator: walks the duty code
// toward a software target by STEP once per update tick, with an immediate
// stop that forces duty and target to zero.
module pwm_duty_ramp
    import pwm_duty_ramp_pkg::*;
#(
    parameter int PERIOD_CYCLES = PWM_PERIOD_CYCLES,
    parameter int TICK_PERIODS  = 1,
    parameter int STEP          = 1,
    parameter int DUTY_MAX      = PWM_DUTY_MAX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DUTY_W-1:0] target,
    input  logic              target_valid,
    input  logic              stop,
    output logic [DUTY_W-1:0] duty_out,
    output logic              at_target,
    output logic              busy,
    output logic              clamped
);

    // One extra bit so duty+STEP and tgt+STEP never wrap for large STEP.
    localparam logic [DUTY_W:0]   STEP_W1 = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] DMAX    = DUTY_W'(DUTY_MAX);

    ramp_state_e       r_state;
    ramp_state_e       w_state_nxt;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_tgt;
    logic              r_at_target;
    logic              r_busy;
    logic              r_clamped;

    logic              w_update_tick;
    logic [DUTY_W:0]   w_up_w1;
    logic [DUTY_W:0]   w_dn_w1;
    logic [DUTY_W:0]   w_dn_lim_w1;
    logic [DUTY_W-1:0] w_duty_step;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic [DUTY_W-1:0] w_tgt_nxt;
    logic              w_clamped_nxt;

    pwm_period_tick #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .TICK_PERIODS  (TICK_PERIODS)
    ) u_period_tick (
        .clock       (clock),
        .reset       (reset),
        .update_tick (w_update_tick)
    );

    assign w_up_w1     = {1'b0, r_duty} + STEP_W1;
    assign w_dn_w1     = {1'b0, r_duty} - STEP_W1;
    assign w_dn_lim_w1 = {1'b0, r_tgt} + STEP_W1;

    // One step toward the current target, saturating at the target so the
    // ramp never overshoots; the down case compares tgt+STEP against duty
    // to avoid an underflowing subtraction.
    always_comb begin
        w_duty_step = r_duty;
        if (r_tgt > r_duty) begin
            if (w_up_w1 >= {1'b0, r_tgt}) begin
                w_duty_step = r_tgt;
            end else begin
                w_duty_step = w_up_w1[DUTY_W-1:0];
            end
        end else if (r_tgt < r_duty) begin
            if (w_dn_lim_w1 >= {1'b0, r_duty}) begin
                w_duty_step = r_tgt;
            end else begin
                w_duty_step = w_dn_w1[DUTY_W-1:0];
            end
        end else begin
            w_duty_step = r_duty;
        end
    end

    // Next-state and datapath: stop dominates; otherwise the step uses the
    // target held before this edge, and a new target only takes effect on
    // the following tick. Direction follows from the post-edge values.
    always_comb begin
        w_state_nxt   = r_state;
        w_duty_nxt    = r_duty;
        w_tgt_nxt     = r_tgt;
        w_clamped_nxt = 1'b0;
        if (stop) begin
            w_state_nxt = ST_STOPPED;
            w_duty_nxt  = '0;
            w_tgt_nxt   = '0;
        end else begin
            if (w_update_tick) begin
                w_duty_nxt = w_duty_step;
            end else begin
                w_duty_nxt = r_duty;
            end
            if (target_valid) begin
                w_tgt_nxt     = clamp_duty(target, DMAX);
                w_clamped_nxt = (target > DMAX);
            end else begin
                w_tgt_nxt = r_tgt;
            end
            if (w_tgt_nxt > w_duty_nxt) begin
                w_state_nxt = ST_RAMP_UP;
            end else if (w_tgt_nxt < w_duty_nxt) begin
                w_state_nxt = ST_RAMP_DOWN;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // State, duty, target and status flags; flags are derived from the
    // next state so they line up with the registered duty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_duty      <= '0;
            r_tgt       <= '0;
            r_at_target <= 1'b1;
            r_busy      <= 1'b0;
            r_clamped   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_duty      <= w_duty_nxt;
            r_tgt       <= w_tgt_nxt;
            r_at_target <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt == ST_RAMP_UP) || (w_state_nxt == ST_RAMP_DOWN);
            r_clamped   <= w_clamped_nxt;
        end
    end

    assign duty_out  = r_duty;
    assign at_target = r_at_target;
    assign busy      = r_busy;
    assign clamped   = r_clamped;

endmodule
